lcd_write_scheduler: RTL

- Sits between two byte-level requesters and the character-LCD 4-bit pins.
- Runs the LCD power-on nibble initialisation once after reset, then arbitrates byte write requests round-robin.
- Each accepted byte goes out as high/low nibble E pulses, with per-command completion waits.
- Requesters never touch LCD timing.

---
 rtl/lcd_write_scheduler.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/lcd_write_scheduler.sv
// Character-LCD 4-bit write scheduler: one-shot power-on nibble init, then
// round-robin arbitration of two byte requesters onto the LCD pins.
//
// state          | meaning
// ST_PWRUP       | power-on delay before the first init nibble
// ST_INIT_SETUP  | init nibble on SF_D, E low
// ST_INIT_PULSE  | init nibble, E high
// ST_INIT_WAIT   | settle time after an init nibble
// ST_IDLE        | init done, waiting for a request
// ST_HI_SETUP    | high nibble on SF_D, E low
// ST_HI_PULSE    | high nibble, E high
// ST_GAP         | E low between the two nibbles
// ST_LO_SETUP    | low nibble on SF_D, E low
// ST_LO_PULSE    | low nibble, E high
// ST_WAIT        | command completion wait
module lcd_write_scheduler #(
  parameter int T_SETUP      = 2,
  parameter int T_PULSE      = 12,
  parameter int T_NIBBLE_GAP = 50,
  parameter int T_CMD        = 2000,
  parameter int T_LONG       = 82000,
  parameter int T_POWERUP    = 750000,
  parameter int T_INIT1      = 205000,
  parameter int T_INIT2      = 5000,
  parameter int T_INIT3      = 2000
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       iReq0_Valid,
  input  logic       iReq0_RS,
  input  logic [7:0] iReq0_Data,
  output logic       oReq0_Ready,
  input  logic       iReq1_Valid,
  input  logic       iReq1_RS,
  input  logic [7:0] iReq1_Data,
  output logic       oReq1_Ready,
  output logic       oInitDone,
  output logic       oBusy,
  output logic       LCD_E,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic [3:0] SF_D,
  output logic       SF_CE0
);

  typedef enum logic [3:0] {
    ST_PWRUP,
    ST_INIT_SETUP,
    ST_INIT_PULSE,
    ST_INIT_WAIT,
    ST_IDLE,
    ST_HI_SETUP,
    ST_HI_PULSE,
    ST_GAP,
    ST_LO_SETUP,
    ST_LO_PULSE,
    ST_WAIT
  } state_t;

  localparam logic [19:0] C_SETUP   = 20'(T_SETUP - 1);
  localparam logic [19:0] C_PULSE   = 20'(T_PULSE - 1);
  localparam logic [19:0] C_GAP     = 20'(T_NIBBLE_GAP - 1);
  localparam logic [19:0] C_CMD     = 20'(T_CMD - 1);
  localparam logic [19:0] C_LONG    = 20'(T_LONG - 1);
  localparam logic [19:0] C_POWERUP = 20'(T_POWERUP - 1);
  localparam logic [19:0] C_INIT1   = 20'(T_INIT1 - 1);
  localparam logic [19:0] C_INIT2   = 20'(T_INIT2 - 1);
  localparam logic [19:0] C_INIT3   = 20'(T_INIT3 - 1);

  state_t      state_q, state_d;
  logic [19:0] cnt_q, cnt_d;
  logic [1:0]  init_idx_q, init_idx_d;
  logic        ptr_q, ptr_d;
  logic        rs_q, rs_d;
  logic        long_q, long_d;
  logic [7:0]  data_q, data_d;
  logic        init_done_q, init_done_d;
  logic        lcd_e_q, lcd_e_d;
  logic        lcd_rs_q, lcd_rs_d;
  logic [3:0]  sf_d_q, sf_d_d;
  logic        gnt0, gnt1, cnt_zero;
  logic        sel_rs;
  logic [7:0]  sel_data;
  logic [19:0] init_wait;
  logic [19:0] load_val;

  // ptr_q = 1 gives requester 1 priority when both are valid
  assign gnt0     = (state_q == ST_IDLE) & iReq0_Valid & (~iReq1_Valid | ~ptr_q);
  assign gnt1     = (state_q == ST_IDLE) & iReq1_Valid & (~iReq0_Valid | ptr_q);
  assign cnt_zero = (cnt_q == 20'd0);
  assign sel_rs   = gnt0 ? iReq0_RS : iReq1_RS;
  assign sel_data = gnt0 ? iReq0_Data : iReq1_Data;

  always_comb begin
    init_wait = C_INIT3;
    case (init_idx_q)
      2'd0:    init_wait = C_INIT1;
      2'd1:    init_wait = C_INIT2;
      default: init_wait = C_INIT3;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q - 20'd1;
    init_idx_d  = init_idx_q;
    ptr_d       = ptr_q;
    rs_d        = rs_q;
    long_d      = long_q;
    data_d      = data_q;
    init_done_d = init_done_q;
    load_val    = C_SETUP;
    case (state_q)
      ST_PWRUP:      if (cnt_zero) state_d = ST_INIT_SETUP;
      ST_INIT_SETUP: if (cnt_zero) state_d = ST_INIT_PULSE;
      ST_INIT_PULSE: if (cnt_zero) state_d = ST_INIT_WAIT;
      ST_INIT_WAIT: begin
        if (cnt_zero) begin
          if (init_idx_q == 2'd3) begin
            state_d     = ST_IDLE;
            init_done_d = 1'b1;
          end else begin
            init_idx_d = init_idx_q + 2'd1;
            state_d    = ST_INIT_SETUP;
          end
        end
      end
      ST_IDLE: begin
        if (gnt0 | gnt1) begin
          ptr_d   = gnt0;
          rs_d    = sel_rs;
          data_d  = sel_data;
          long_d  = ~sel_rs & (sel_data[7:2] == 6'd0);
          state_d = ST_HI_SETUP;
        end
      end
      ST_HI_SETUP: if (cnt_zero) state_d = ST_HI_PULSE;
      ST_HI_PULSE: if (cnt_zero) state_d = ST_GAP;
      ST_GAP:      if (cnt_zero) state_d = ST_LO_SETUP;
      ST_LO_SETUP: if (cnt_zero) state_d = ST_LO_PULSE;
      ST_LO_PULSE: if (cnt_zero) state_d = ST_WAIT;
      ST_WAIT:     if (cnt_zero) state_d = ST_IDLE;
      default:     state_d = ST_PWRUP;
    endcase

    case (state_d)
      ST_INIT_PULSE, ST_HI_PULSE, ST_LO_PULSE: load_val = C_PULSE;
      ST_INIT_WAIT: load_val = init_wait;
      ST_GAP:       load_val = C_GAP;
      ST_WAIT:      load_val = long_q ? C_LONG : C_CMD;
      ST_PWRUP:     load_val = C_POWERUP;
      default:      load_val = C_SETUP;
    endcase
    if (state_d != state_q) cnt_d = load_val;
  end

  // Pin values derive from the current state and are registered, so the
  // pins trail the state by one cycle but every duration is preserved.
  always_comb begin
    lcd_e_d  = 1'b0;
    lcd_rs_d = 1'b0;
    sf_d_d   = 4'h0;
    case (state_q)
      ST_INIT_SETUP, ST_INIT_PULSE, ST_INIT_WAIT: begin
        sf_d_d  = (init_idx_q == 2'd3) ? 4'h2 : 4'h3;
        lcd_e_d = (state_q == ST_INIT_PULSE);
      end
      ST_HI_SETUP, ST_HI_PULSE, ST_GAP: begin
        sf_d_d   = data_q[7:4];
        lcd_rs_d = rs_q;
        lcd_e_d  = (state_q == ST_HI_PULSE);
      end
      ST_LO_SETUP, ST_LO_PULSE, ST_WAIT: begin
        sf_d_d   = data_q[3:0];
        lcd_rs_d = rs_q;
        lcd_e_d  = (state_q == ST_LO_PULSE);
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q     <= ST_PWRUP;
      cnt_q       <= C_POWERUP;
      init_idx_q  <= 2'd0;
      ptr_q       <= 1'b0;
      rs_q        <= 1'b0;
      long_q      <= 1'b0;
      data_q      <= 8'h00;
      init_done_q <= 1'b0;
      lcd_e_q     <= 1'b0;
      lcd_rs_q    <= 1'b0;
      sf_d_q      <= 4'h0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_idx_q  <= init_idx_d;
      ptr_q       <= ptr_d;
      rs_q        <= rs_d;
      long_q      <= long_d;
      data_q      <= data_d;
      init_done_q <= init_done_d;
      lcd_e_q     <= lcd_e_d;
      lcd_rs_q    <= lcd_rs_d;
      sf_d_q      <= sf_d_d;
    end
  end

  assign oReq0_Ready = gnt0;
  assign oReq1_Ready = gnt1;
  assign oInitDone   = init_done_q;
  assign oBusy       = (state_q != ST_IDLE);
  assign LCD_E       = lcd_e_q;
  assign LCD_RS      = lcd_rs_q;
  assign LCD_RW      = 1'b0;
  assign SF_D        = sf_d_q;
  assign SF_CE0      = 1'b1;

endmodule
